// File: rtl/rob_core.sv
// rob_core: parametrised reorder buffer.
//   Entries are allocated in program order by the decode stage, marked
//   complete by the functional-unit forwarding buses and retired in order,
//   up to COMMIT_W per cycle. A flush discards every in-flight entry.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush_i              synchronous discard of all entries
//   disp_*_i             per-lane allocation request (valid/pc/wr/dst)
//   disp_ready_o         at least DISPATCH_W entries are free
//   disp_idx_o           index assigned to each dispatch lane, (tail+i) mod DEPTH
//   wb_bus_i             per port {cc[2:0], valid, idx, value}, port 0 in the LSBs
//   commit_stall_i       holds off retirement this cycle
//   commit_*_o           per-lane fields of the retiring entries
//   count_o, empty_o, full_o  occupancy of the buffer
module rob_core #(
    parameter int DEPTH      = 64,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int DISPATCH_W = 4,
    parameter int WB_PORTS   = 4,
    parameter int COMMIT_W   = 2,
    parameter int DATA_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic [DISPATCH_W-1:0]          disp_valid_i,
    input  logic [DISPATCH_W*16-1:0]       disp_pc_i,
    input  logic [DISPATCH_W-1:0]          disp_wr_i,
    input  logic [DISPATCH_W*3-1:0]        disp_dst_i,
    output logic                           disp_ready_o,
    output logic [DISPATCH_W*IDX_W-1:0]    disp_idx_o,
    input  logic [WB_PORTS*(4+IDX_W+DATA_W)-1:0] wb_bus_i,
    input  logic                           commit_stall_i,
    output logic [COMMIT_W-1:0]            commit_valid_o,
    output logic [COMMIT_W-1:0]            commit_wr_o,
    output logic [COMMIT_W*3-1:0]          commit_dst_o,
    output logic [COMMIT_W*DATA_W-1:0]     commit_value_o,
    output logic [COMMIT_W*3-1:0]          commit_cc_o,
    output logic [COMMIT_W*16-1:0]         commit_pc_o,
    output logic [IDX_W:0]                 count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int WB_W = 4 + IDX_W + DATA_W;

    // Entry state
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [2:0]        cc_q    [DEPTH];
    logic [2:0]        cc_d    [DEPTH];
    logic [15:0]       pc_q    [DEPTH];
    logic [15:0]       pc_d    [DEPTH];
    logic [DEPTH-1:0]  wr_q, wr_d;
    logic [2:0]        dst_q   [DEPTH];
    logic [2:0]        dst_d   [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    // Decoded writeback ports
    logic              wb_valid [WB_PORTS];
    logic [IDX_W-1:0]  wb_idx   [WB_PORTS];
    logic [DATA_W-1:0] wb_value [WB_PORTS];
    logic [2:0]        wb_cc    [WB_PORTS];

    logic [COMMIT_W:0] commit_chain;
    logic [IDX_W:0]    n_ret;
    logic [IDX_W:0]    n_disp;

    genvar gi;
    generate
        for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb
            assign wb_value[gi] = wb_bus_i[gi*WB_W +: DATA_W];
            assign wb_idx[gi]   = wb_bus_i[gi*WB_W + DATA_W +: IDX_W];
            assign wb_valid[gi] = wb_bus_i[gi*WB_W + DATA_W + IDX_W];
            assign wb_cc[gi]    = wb_bus_i[gi*WB_W + DATA_W + IDX_W + 1 +: 3];
        end

        for (gi = 0; gi < DISPATCH_W; gi++) begin : g_didx
            assign disp_idx_o[gi*IDX_W +: IDX_W] = tail_q + IDX_W'(gi);
        end

        // Retire lanes form a contiguous prefix: each lane needs every older
        // lane to retire as well, so the chain breaks at the first incomplete entry.
        assign commit_chain[0] = ~commit_stall_i;
        for (gi = 0; gi < COMMIT_W; gi++) begin : g_commit
            logic [IDX_W-1:0] cidx;
            assign cidx = head_q + IDX_W'(gi);
            assign commit_chain[gi+1] = commit_chain[gi] & busy_q[cidx] & done_q[cidx]
                                        & (count_q > (IDX_W+1)'(gi));
            assign commit_valid_o[gi] = commit_chain[gi+1];
            assign commit_wr_o[gi]    = commit_chain[gi+1] & wr_q[cidx];
            assign commit_dst_o[gi*3 +: 3]        = commit_chain[gi+1] ? dst_q[cidx]   : 3'd0;
            assign commit_cc_o[gi*3 +: 3]         = commit_chain[gi+1] ? cc_q[cidx]    : 3'd0;
            assign commit_pc_o[gi*16 +: 16]       = commit_chain[gi+1] ? pc_q[cidx]    : 16'd0;
            assign commit_value_o[gi*DATA_W +: DATA_W] = commit_chain[gi+1] ? value_q[cidx] : '0;
        end
    endgenerate

    // Occupancy flags come from registered state only; same-cycle
    // retirement is not credited toward disp_ready_o.
    assign disp_ready_o = (count_q <= (IDX_W+1)'(DEPTH - DISPATCH_W));
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == (IDX_W+1)'(DEPTH));

    assign n_ret  = (IDX_W+1)'($countones(commit_valid_o));
    assign n_disp = disp_ready_o ? (IDX_W+1)'($countones(disp_valid_i)) : '0;

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        value_d = value_q;
        cc_d    = cc_q;
        pc_d    = pc_q;
        wr_d    = wr_q;
        dst_d   = dst_q;
        head_d  = head_q + n_ret[IDX_W-1:0];
        tail_d  = tail_q + n_disp[IDX_W-1:0];
        count_d = count_q + n_disp - n_ret;

        // Highest port first so the lowest-numbered port overwrites on a clash.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && busy_q[wb_idx[p]]) begin
                done_d[wb_idx[p]]  = 1'b1;
                value_d[wb_idx[p]] = wb_value[p];
                cc_d[wb_idx[p]]    = wb_cc[p];
            end
        end

        for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_valid_o[j]) begin
                busy_d[head_q + IDX_W'(j)] = 1'b0;
                done_d[head_q + IDX_W'(j)] = 1'b0;
            end
        end

        // Dispatch only targets free entries, so it never collides with the
        // writeback or retire updates above.
        if (disp_ready_o) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid_i[i]) begin
                    busy_d[tail_q + IDX_W'(i)] = 1'b1;
                    done_d[tail_q + IDX_W'(i)] = 1'b0;
                    pc_d[tail_q + IDX_W'(i)]   = disp_pc_i[i*16 +: 16];
                    wr_d[tail_q + IDX_W'(i)]   = disp_wr_i[i];
                    dst_d[tail_q + IDX_W'(i)]  = disp_dst_i[i*3 +: 3];
                end
            end
        end

        if (flush_i) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            done_q  <= '0;
            wr_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                value_q[k] <= '0;
                cc_q[k]    <= '0;
                pc_q[k]    <= '0;
                dst_q[k]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            value_q <= value_d;
            cc_q    <= cc_d;
            pc_q    <= pc_d;
            dst_q   <= dst_d;
        end
    end

endmodule
